// File: rtl/mips_pkg.sv
// Shared pipeline-control types and constants for the MIPS hazard unit.
package mips_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination feeds either source of the ID instruction.
module load_use_detector
  import mips_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] wr_addr,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       load_use
);

  // $zero is never a real dependency, so a load targeting it cannot stall
  assign load_use = mem_read && (wr_addr != REG_ZERO) &&
                    ((wr_addr == rs) || (wr_addr == rt));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, taken-branch and mul/div waits.
// Define MULDIV_STALL_EN to build the MD_WAIT state, wait counter and timeout.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int MD_TIMEOUT  = MD_TIMEOUT_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_ex_mem_read,
  input  logic [4:0]             id_ex_write_reg_addr,
  input  logic [4:0]             if_id_instr_rs,
  input  logic [4:0]             if_id_instr_rt,
  input  logic                   ex_branch_taken,
  input  logic                   id_md_op,
  input  logic                   md_done,
  input  logic                   stall_cnt_clr,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   md_start,
  output logic                   md_abort,
  output logic                   md_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic   load_use;
  logic   md_req;
  logic   md_timeout;
  state_e state;

  load_use_detector u_lud (
    .mem_read (id_ex_mem_read),
    .wr_addr  (id_ex_write_reg_addr),
    .rs       (if_id_instr_rs),
    .rt       (if_id_instr_rt),
    .load_use (load_use)
  );

`ifdef MULDIV_STALL_EN
  logic [7:0] wait_cnt;
  logic       md_err_q;

  assign md_req     = id_md_op;
  assign md_timeout = (state == MD_WAIT) && !md_done && (wait_cnt == 8'(MD_TIMEOUT));
  assign md_error   = md_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      md_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!ex_branch_taken && !load_use && id_md_op) begin
            state    <= MD_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MD_WAIT: begin
          // md_done is checked first so a result on the timeout cycle is kept
          if (md_done) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (md_timeout) begin
            state    <= RUN;
            wait_cnt <= '0;
            md_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_md;

  assign unused_md  = id_md_op ^ md_done;
  assign md_req     = 1'b0;
  assign md_timeout = 1'b0;
  assign md_error   = 1'b0;
  assign state      = RUN;
`endif

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    md_start     = 1'b0;
    md_abort     = 1'b0;
    // reset holds the pipeline in plain run regardless of hazard inputs
    if (rst_n) begin
      if (state == MD_WAIT) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        md_abort     = md_timeout;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (md_req) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        md_start     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall_cnt_clr)
      stall_cycles <= '0;
    else if (!pc_write && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed checks for hazard_stall_ctrl; mul/div checks follow MULDIV_STALL_EN.
module tb_hazard_stall_ctrl;
  import mips_pkg::*;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_ex_mem_read;
  logic [4:0]    id_ex_write_reg_addr, if_id_instr_rs, if_id_instr_rt;
  logic          ex_branch_taken, id_md_op, md_done, stall_cnt_clr;
  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic          md_start, md_abort, md_error;
  logic [CW-1:0] stall_cycles;

  int n_chk = 0;
  int n_err = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_TIMEOUT(TO), .STALL_CNT_W(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .id_ex_mem_read       (id_ex_mem_read),
    .id_ex_write_reg_addr (id_ex_write_reg_addr),
    .if_id_instr_rs       (if_id_instr_rs),
    .if_id_instr_rt       (if_id_instr_rt),
    .ex_branch_taken      (ex_branch_taken),
    .id_md_op             (id_md_op),
    .md_done              (md_done),
    .stall_cnt_clr        (stall_cnt_clr),
    .pc_write             (pc_write),
    .if_id_write          (if_id_write),
    .id_ex_bubble         (id_ex_bubble),
    .if_id_flush          (if_id_flush),
    .md_start             (md_start),
    .md_abort             (md_abort),
    .md_error             (md_error),
    .stall_cycles         (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_ex_mem_read = 1'b0; id_ex_write_reg_addr = 5'd0;
    if_id_instr_rs = 5'd0; if_id_instr_rt = 5'd0;
    ex_branch_taken = 1'b0; id_md_op = 1'b0; md_done = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [4:0] a, input logic [4:0] s, input logic [4:0] t);
    id_ex_mem_read = 1'b1; id_ex_write_reg_addr = a;
    if_id_instr_rs = s; if_id_instr_rt = t;
  endtask

  // advance one clock; exp_sc tracks the saturating stall counter
  task automatic step(input bit stalled);
    if (stalled && exp_sc < (1 << CW) - 1) exp_sc++;
    @(posedge clk); #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    #2;
    chk(tag, {26'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, md_start, md_abort},
        {26'd0, exp});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    load(5'd5, 5'd5, 5'd0);
    #3;
    chk_ctl("reset_ctl", 6'b110000);
    chk("reset_sc", 32'(stall_cycles), 0);
    chk("reset_err", 32'(md_error), 0);
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    load(5'd5, 5'd5, 5'd0);           chk_ctl("lu_rs", 6'b001000); step(1);
    idle();                           chk_ctl("lu_after", 6'b110000);
    chk("lu_sc", 32'(stall_cycles), 1);
    load(5'd7, 5'd3, 5'd7);           chk_ctl("lu_rt", 6'b001000); step(1);
    load(5'd0, 5'd0, 5'd0);           chk_ctl("lu_zero", 6'b110000); step(0);
    id_ex_mem_read = 1'b0; id_ex_write_reg_addr = 5'd5; if_id_instr_rs = 5'd5;
                                      chk_ctl("no_load", 6'b110000); step(0);
    load(5'd9, 5'd9, 5'd9); ex_branch_taken = 1'b1;
                                      chk_ctl("br_over_lu", 6'b111100); step(0);
    idle();
    chk("sc_after_br", 32'(stall_cycles), 32'(exp_sc));

`ifdef MULDIV_STALL_EN
    // md op finishing in its 6th wait cycle, branch/load-use ignored while waiting
    id_md_op = 1'b1;                  chk_ctl("md_start", 6'b001010); step(1);
    id_md_op = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      md_done = (i == 6);
      ex_branch_taken = (i == 2);
      if (i == 3) load(5'd4, 5'd4, 5'd0); else id_ex_mem_read = 1'b0;
      chk_ctl($sformatf("md_wait%0d", i), 6'b001000);
      step(1);
    end
    idle();                           chk_ctl("md_run", 6'b110000);
    chk("md_err0", 32'(md_error), 0);
    chk("md_sc", 32'(stall_cycles), 32'(exp_sc));
    md_done = 1'b1;                   chk_ctl("done_in_run", 6'b110000); step(0);
    idle();

    // md_done on the timeout cycle wins over abort
    id_md_op = 1'b1;                  chk_ctl("tie_start", 6'b001010); step(1);
    id_md_op = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      md_done = (i == TO);
      chk_ctl($sformatf("tie_wait%0d", i), 6'b001000);
      step(1);
    end
    idle();                           chk_ctl("tie_run", 6'b110000);
    chk("tie_err", 32'(md_error), 0);

    // no md_done: abort pulses in the TO-th wait cycle, error sticks
    id_md_op = 1'b1;                  chk_ctl("to_start", 6'b001010); step(1);
    id_md_op = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      chk_ctl($sformatf("to_wait%0d", i), (i == TO) ? 6'b001001 : 6'b001000);
      step(1);
    end
    chk_ctl("to_run", 6'b110000);
    chk("to_err", 32'(md_error), 1);
    step(0);
    chk("to_err_sticky", 32'(md_error), 1);
    chk("to_sc", 32'(stall_cycles), 32'(exp_sc));
`else
    id_md_op = 1'b1;                  chk_ctl("md_ignored", 6'b110000); step(0);
    idle(); md_done = 1'b1;           chk_ctl("done_ignored", 6'b110000); step(0);
    idle();
    chk("md_off_sc", 32'(stall_cycles), 32'(exp_sc));
    chk("md_off_err", 32'(md_error), 0);
`endif

    // saturation after 20 stall cycles, then clear while still stalling
    load(5'd6, 5'd0, 5'd6);
    for (int i = 0; i < 20; i++) step(1);
    #2;
    chk("sat_sc", 32'(stall_cycles), 15);
    chk("sat_model", 32'(stall_cycles), 32'(exp_sc));
    stall_cnt_clr = 1'b1; step(1);
    chk("clr_sc", 32'(stall_cycles), 0);
    stall_cnt_clr = 1'b0; step(1);
    chk("clr_resume", 32'(stall_cycles), 1);
    idle(); step(0);

`ifdef MULDIV_STALL_EN
    // reset mid-wait abandons the op quietly
    id_md_op = 1'b1; step(1);
    id_md_op = 1'b0; step(1); step(1);
    #1 rst_n = 1'b0;
    #1;
    chk_ctl("rst_mid_md", 6'b110000);
    chk("rst_mid_err", 32'(md_error), 0);
`else
    load(5'd8, 5'd8, 5'd0); step(1);
    #1 rst_n = 1'b0;
    #1;
    chk_ctl("rst_mid_stall", 6'b110000);
`endif
    chk("rst_mid_sc", 32'(stall_cycles), 0);
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_ctl("post_rst", 6'b110000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, meaning max MD_WAIT cycles before abort (range 2..255).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning stall performance counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_ex_mem_read  input  1  instruction in EX is a load.
REQ-006 SHALL have port id_ex_write_reg_addr  input  5  load destination register.
REQ-007 SHALL have ports if_id_instr_rs, if_id_instr_rt  input  5 each  source registers of the instruction in ID.
REQ-008 SHALL have port ex_branch_taken  input  1  branch or jump resolved taken in EX.
REQ-009 SHALL have port id_md_op  input  1  ID instruction is a multi-cycle mul/div.
REQ-010 SHALL have port md_done  input  1  mul/div unit result ready, 1-cycle pulse.
REQ-011 SHALL have port stall_cnt_clr  input  1  synchronous clear of stall_cycles.
REQ-012 SHALL have outputs pc_write, if_id_write, id_ex_bubble, if_id_flush, md_start, md_abort, md_error  output  1 each.
REQ-013 SHALL have output stall_cycles  output  STALL_CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-014 FSM states SHALL be RUN and MD_WAIT; control outputs SHALL be combinational from state and inputs.
REQ-015 load_use SHALL be id_ex_mem_read & (id_ex_write_reg_addr!=0) & (addr==rs | addr==rt).
REQ-016 RUN priority SHALL be ex_branch_taken > load_use > id_md_op.
REQ-017 RUN + ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; next RUN.
REQ-018 RUN + load_use: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; next RUN.
REQ-019 RUN + id_md_op, no higher event: md_start=1 for one cycle, pc_write=0, if_id_write=0, id_ex_bubble=1; next MD_WAIT, wait counter loaded with 1.
REQ-020 RUN with no event: pc_write=1, if_id_write=1, all others 0.
REQ-021 MD_WAIT: pc_write=0, if_id_write=0, id_ex_bubble=1; ex_branch_taken and load_use SHALL be ignored.
REQ-022 MD_WAIT + md_done: next RUN, outputs still stalled that cycle.
REQ-023 MD_WAIT, no md_done, counter==MD_TIMEOUT: md_abort=1 one cycle, md_error set sticky, next RUN.
REQ-024 md_done and timeout in the same cycle: md_done SHALL win, no abort.
REQ-025 md_done in RUN SHALL be ignored.
REQ-026 stall_cycles SHALL increment when pc_write=0, saturate at all-ones; stall_cnt_clr SHALL take priority over increment.

Reset
REQ-027 rst_n low SHALL force state RUN, wait counter 0, stall_cycles 0, md_error 0, immediately and asynchronously.
REQ-028 During reset outputs SHALL be pc_write=1, if_id_write=1, all others 0; reset mid-MD_WAIT SHALL abandon the op without md_abort.

Configuration
REQ-029 Macro MULDIV_STALL_EN SHALL compile in the MD_WAIT state, wait counter and timeout logic.
REQ-030 Without MULDIV_STALL_EN: id_md_op and md_done ignored, md_start/md_abort/md_error tied 0, state always RUN; port list unchanged.

Structure
REQ-031 Shared package mips_pkg SHALL hold the FSM state typedef, REG_ZERO constant and default MD_TIMEOUT.
REQ-032 Load-use compare SHALL be a sub-module load_use_detector; the rest stays in hazard_stall_ctrl.

Verification
REQ-033 id_ex_mem_read=1, addr=5, rs=5 -> one cycle pc_write=0, id_ex_bubble=1; stall_cycles=1.
REQ-034 id_ex_mem_read=1, addr=0, rs=0 -> no stall, pc_write=1.
REQ-035 ex_branch_taken=1 with load_use=1 in the same cycle -> if_id_flush=1, pc_write=1, no stall.
REQ-036 id_md_op=1, md_done after 10 cycles -> md_start pulse, 11 stalled cycles, RUN next; md_error=0.
REQ-037 id_md_op=1, md_done never, MD_TIMEOUT=8 -> md_abort pulse in the 8th wait cycle, md_error=1 until rst_n low.
REQ-038 STALL_CNT_W=4, 20 stall cycles -> stall_cycles holds 15; stall_cnt_clr=1 while stalling -> 0 next cycle.
